// File: rtl/bpi_pkg.sv
// Shared action codes, FSM state encoding and timeout default for the BPI flash arbiter.
package bpi_pkg;

    localparam logic [2:0]  ACT_READ            = 3'b001;
    localparam logic [2:0]  ACT_PROG            = 3'b010;
    localparam logic [2:0]  ACT_ERASE           = 3'b100;
    localparam logic [27:0] TIMEOUT_CYC_DEFAULT = 28'd200_000_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_DONE,
        S_HOLD
    } state_t;

    function automatic logic action_legal(input logic [2:0] act);
        return (act == ACT_READ) || (act == ACT_PROG) || (act == ACT_ERASE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at slot ptr and wraps around.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (32'(ptr) + i) % N)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bpi_access_arb.sv
// Shares one BPI flash interface between N_REQ requesters: round-robin grant,
// single outstanding action, start-wait and busy timeouts, optional grant lock.
module bpi_access_arb
    import bpi_pkg::*;
#(
    parameter int unsigned N_REQ       = 3,
    parameter logic [27:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int unsigned START_WAIT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_lock,
    input  logic [3*N_REQ-1:0]    req_action,
    input  logic [24*N_REQ-1:0]   req_addr,
    input  logic [16*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic [15:0]           rdata,
    output logic                  rdata_valid,
    output logic [2:0]            ACTION_EN,
    output logic [23:0]           ADDR,
    output logic [15:0]           BPI_din,
    input  logic [15:0]           BPI_dout,
    input  logic                  read_valid,
    input  logic                  write_start,
    input  logic                  bpi_idle
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, next_state;
    logic [N_REQ-1:0] grant_r, arb_grant;
    logic [IW-1:0]    owner_idx, arb_idx, sel_idx, ptr;
    logic [2:0]       action_r, sel_action;
    logic [23:0]      sel_addr;
    logic [15:0]      sel_wdata;
    logic [27:0]      cnt;
    logic             err_flag, rd_seen;
    logic             owner_req, owner_lock, busy_op;
    logic             take_grant, drop_grant, start, timeout;
    logic             unused_write_start;

    assign unused_write_start = write_start;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            if (arb_grant[i]) arb_idx = IW'(i);
    end

    // New operations come from the arbiter winner in IDLE, from the locked owner in HOLD.
    assign sel_idx = (state == S_IDLE) ? arb_idx : owner_idx;

    always_comb begin
        sel_action = '0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_action = req_action[3*i +: 3];
                sel_addr   = req_addr[24*i +: 24];
                sel_wdata  = req_wdata[16*i +: 16];
            end
        end
    end

    assign owner_req  = |(req & grant_r);
    assign owner_lock = |(req_lock & grant_r);
    assign busy_op    = (state == S_ISSUE) || (state == S_WAIT_BUSY) || (state == S_WAIT_IDLE);

    always_comb begin
        next_state = state;
        take_grant = 1'b0;
        drop_grant = 1'b0;
        start      = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bpi_idle && (|req)) begin
                    take_grant = 1'b1;
                    start      = 1'b1;
                    next_state = action_legal(sel_action) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!bpi_idle)
                    next_state = S_WAIT_IDLE;
                else if (cnt == 28'(START_WAIT - 1))
                    next_state = S_DONE;
            end
            S_WAIT_IDLE: begin
                if (bpi_idle) begin
                    next_state = S_DONE;
                end else if (cnt == TIMEOUT_CYC - 28'd1) begin
                    next_state = S_DONE;
                    timeout    = 1'b1;
                end
            end
            S_DONE: begin
                if (owner_lock) begin
                    next_state = S_HOLD;
                end else begin
                    next_state = S_IDLE;
                    drop_grant = 1'b1;
                end
            end
            S_HOLD: begin
                if (owner_req) begin
                    start      = 1'b1;
                    next_state = action_legal(sel_action) ? S_ISSUE : S_DONE;
                end else if (!owner_lock) begin
                    next_state = S_IDLE;
                    drop_grant = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant_r     <= '0;
            owner_idx   <= '0;
            ptr         <= '0;
            action_r    <= '0;
            ADDR        <= '0;
            BPI_din     <= '0;
            cnt         <= '0;
            err_flag    <= 1'b0;
            rd_seen     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= next_state;
            rdata_valid <= 1'b0;
            if (take_grant) begin
                grant_r   <= arb_grant;
                owner_idx <= arb_idx;
                ptr       <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
            end else if (drop_grant) begin
                grant_r <= '0;
            end
            if (start) begin
                action_r <= sel_action;
                ADDR     <= sel_addr;
                BPI_din  <= sel_wdata;
                err_flag <= !action_legal(sel_action);
                rd_seen  <= 1'b0;
            end
            if (timeout)
                err_flag <= 1'b1;
            if (next_state != state)
                cnt <= '0;
            else if (state == S_WAIT_BUSY || state == S_WAIT_IDLE)
                cnt <= cnt + 28'd1;
            if (busy_op && read_valid && !rd_seen && action_r == ACT_READ) begin
                rdata       <= BPI_dout;
                rdata_valid <= 1'b1;
                rd_seen     <= 1'b1;
            end
        end
    end

    assign grant     = grant_r;
    assign done      = (state == S_DONE) ? grant_r : '0;
    assign err       = (state == S_DONE && err_flag) ? grant_r : '0;
    assign ACTION_EN = (state == S_ISSUE) ? action_r : 3'b000;

endmodule

// File: tb/tb_bpi_access_arb.sv
// Directed table-driven bench for bpi_access_arb with a small behavioural flash model.
module tb_bpi_access_arb;

    logic        clk, rst;
    logic [2:0]  req, req_lock;
    logic [8:0]  req_action;
    logic [71:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  grant, done, err;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic [2:0]  ACTION_EN;
    logic [23:0] ADDR;
    logic [15:0] BPI_din;
    logic [15:0] BPI_dout;
    logic        read_valid, write_start, bpi_idle;

    int n_checks = 0;
    int n_fail   = 0;

    bpi_access_arb #(
        .N_REQ       (3),
        .TIMEOUT_CYC (28'd100),
        .START_WAIT  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_lock    (req_lock),
        .req_action  (req_action),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .ACTION_EN   (ACTION_EN),
        .ADDR        (ADDR),
        .BPI_din     (BPI_din),
        .BPI_dout    (BPI_dout),
        .read_valid  (read_valid),
        .write_start (write_start),
        .bpi_idle    (bpi_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  req;
        logic [8:0]  acts;
        int          busy;
        logic [15:0] rd;
        logic [2:0]  exp_grant;
        logic [2:0]  exp_act;
        logic        exp_err;
        int          exp_rvs;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] slot_addr(input logic [2:0] oh);
        case (oh)
            3'b001:  return 24'h000100;
            3'b010:  return 24'h0ABCDE;
            3'b100:  return 24'h001234;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [15:0] slot_wdata(input logic [2:0] oh);
        case (oh)
            3'b001:  return 16'h1357;
            3'b010:  return 16'hBEEF;
            3'b100:  return 16'h2468;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (grant != 3'b000) ok = 1'b1;
        end
    endtask

    // Flash model: goes busy for `busy` cycles after a strobe, pulses read_valid
    // twice near the end (first with rd, second with ~rd), then returns idle.
    task automatic flash_txn(input int busy, input logic [15:0] rd, input logic [2:0] mon,
                             output int strobes, output logic [2:0] act, output logic [23:0] a,
                             output logic [15:0] d, output int rvs, output logic [15:0] rdv,
                             output logic got_done, output logic [2:0] dv, output logic [2:0] ev,
                             output int lat, output int gbad);
        int s, cyc;
        s = -1; cyc = 0; strobes = 0; act = '0; a = '0; d = '0; rvs = 0; rdv = '0;
        got_done = 1'b0; dv = '0; ev = '0; lat = -1; gbad = 0;
        while (!got_done && cyc < 300) begin
            if (ACTION_EN != 3'b000) begin
                strobes++; act = ACTION_EN; a = ADDR; d = BPI_din; s = cyc;
            end
            if (rdata_valid) begin
                if (rvs == 0) rdv = rdata;
                rvs++;
            end
            if (mon != 3'b000 && grant != mon) gbad++;
            if (done != 3'b000) begin
                got_done = 1'b1; dv = done; ev = err;
                if (s >= 0) lat = cyc - s;
            end else begin
                bpi_idle   = !(s >= 0 && cyc - s < busy);
                read_valid = (s >= 0 && busy >= 2 && (cyc - s == busy - 2 || cyc - s == busy - 1));
                BPI_dout   = (s >= 0 && cyc - s == busy - 2) ? rd : ~rd;
                @(negedge clk);
                cyc++;
            end
        end
        bpi_idle   = 1'b1;
        read_valid = 1'b0;
    endtask

    initial begin
        logic        ok, gd;
        int          st, rv, lt, gb, bad;
        logic [2:0]  ac, dv, ev;
        logic [23:0] a;
        logic [15:0] d, rdv;

        vecs[0] = '{3'b111, 9'b001_010_001, 5,    16'h1111, 3'b001, 3'b001, 1'b0, 1, 6};
        vecs[1] = '{3'b110, 9'b001_010_001, 4,    16'h7777, 3'b010, 3'b010, 1'b0, 0, 5};
        vecs[2] = '{3'b100, 9'b001_010_001, 5,    16'hA5A5, 3'b100, 3'b001, 1'b0, 1, 6};
        vecs[3] = '{3'b001, 9'b001_010_001, 3,    16'h0F0F, 3'b001, 3'b001, 1'b0, 1, 4};
        vecs[4] = '{3'b011, 9'b001_010_001, 0,    16'h0000, 3'b010, 3'b010, 1'b0, 0, 9};
        vecs[5] = '{3'b011, 9'b001_010_001, 2,    16'h5A5A, 3'b001, 3'b001, 1'b0, 1, 3};
        vecs[6] = '{3'b100, 9'b011_010_001, 0,    16'h0000, 3'b100, 3'b000, 1'b1, 0, 0};
        vecs[7] = '{3'b010, 9'b001_100_001, 1000, 16'h0000, 3'b010, 3'b100, 1'b1, 0, 102};

        rst = 1'b1; req = '0; req_lock = '0; req_action = '0;
        req_addr  = {24'h001234, 24'h0ABCDE, 24'h000100};
        req_wdata = {16'h2468, 16'hBEEF, 16'h1357};
        BPI_dout = '0; read_valid = 1'b0; write_start = 1'b0; bpi_idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset grant", 32'(grant), 0);
        chk("reset done", 32'(done), 0);
        chk("reset ACTION_EN", 32'(ACTION_EN), 0);
        chk("reset ADDR", 32'(ADDR), 0);
        chk("reset rdata_valid", 32'(rdata_valid), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_action = vecs[i].acts;
            req        = vecs[i].req;
            wait_grant(ok);
            chk($sformatf("v%0d grant seen", i), 32'(ok), 1);
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            flash_txn(vecs[i].busy, vecs[i].rd, 3'b000, st, ac, a, d, rv, rdv, gd, dv, ev, lt, gb);
            chk($sformatf("v%0d done seen", i), 32'(gd), 1);
            chk($sformatf("v%0d strobes", i), 32'(st), (vecs[i].exp_act != 3'b000) ? 1 : 0);
            chk($sformatf("v%0d done", i), 32'(dv), 32'(vecs[i].exp_grant));
            chk($sformatf("v%0d err", i), 32'(ev), vecs[i].exp_err ? 32'(vecs[i].exp_grant) : 0);
            chk($sformatf("v%0d rdata pulses", i), 32'(rv), 32'(vecs[i].exp_rvs));
            if (vecs[i].exp_rvs != 0)
                chk($sformatf("v%0d rdata", i), 32'(rdv), 32'(vecs[i].rd));
            if (vecs[i].exp_act != 3'b000) begin
                chk($sformatf("v%0d action", i), 32'(ac), 32'(vecs[i].exp_act));
                chk($sformatf("v%0d addr", i), 32'(a), 32'(slot_addr(vecs[i].exp_grant)));
                chk($sformatf("v%0d din", i), 32'(d), 32'(slot_wdata(vecs[i].exp_grant)));
                chk($sformatf("v%0d addr at done", i), 32'(ADDR), 32'(slot_addr(vecs[i].exp_grant)));
                chk($sformatf("v%0d latency", i), 32'(lt), 32'(vecs[i].exp_lat));
            end
            req = '0;
        end

        // Locked burst: slot 1 erases then programs while slot 0 waits.
        req_action = 9'b001_100_001; req_lock = 3'b010; req = 3'b010;
        wait_grant(ok);
        chk("lock grant", 32'(grant), 32'(3'b010));
        req[0] = 1'b1;
        flash_txn(3, 16'h0000, 3'b010, st, ac, a, d, rv, rdv, gd, dv, ev, lt, gb);
        chk("lock erase action", 32'(ac), 32'(3'b100));
        chk("lock erase done", 32'(dv), 32'(3'b010));
        chk("lock erase grant held", 32'(gb), 0);
        req_action[5:3] = 3'b010;
        @(negedge clk);
        chk("lock hold grant", 32'(grant), 32'(3'b010));
        flash_txn(3, 16'h0000, 3'b010, st, ac, a, d, rv, rdv, gd, dv, ev, lt, gb);
        chk("lock prog strobes", 32'(st), 1);
        chk("lock prog action", 32'(ac), 32'(3'b010));
        chk("lock prog done", 32'(dv), 32'(3'b010));
        chk("lock prog grant held", 32'(gb), 0);
        req[1] = 1'b0; req_lock = '0;
        wait_grant(ok);
        chk("after unlock grant", 32'(grant), 32'(3'b001));
        flash_txn(2, 16'h3C3C, 3'b001, st, ac, a, d, rv, rdv, gd, dv, ev, lt, gb);
        chk("after unlock done", 32'(dv), 32'(3'b001));
        chk("after unlock rdata", 32'(rdv), 32'(16'h3C3C));
        req = '0;

        // Reset in the middle of a long busy period, then recovery.
        req_action = 9'b001_010_001; req = 3'b100;
        wait_grant(ok);
        chk("abort grant", 32'(grant), 32'(3'b100));
        bpi_idle = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort grant cleared", 32'(grant), 0);
        chk("abort done", 32'(done), 0);
        chk("abort err", 32'(err), 0);
        chk("abort ACTION_EN", 32'(ACTION_EN), 0);
        chk("abort ADDR", 32'(ADDR), 0);
        chk("abort BPI_din", 32'(BPI_din), 0);
        chk("abort rdata", 32'(rdata), 0);
        chk("abort rdata_valid", 32'(rdata_valid), 0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (grant != 3'b000 || done != 3'b000) bad++;
        end
        chk("no grant while flash busy", 32'(bad), 0);
        bpi_idle = 1'b1;
        wait_grant(ok);
        chk("recovery grant", 32'(grant), 32'(3'b100));
        flash_txn(5, 16'hC3C3, 3'b100, st, ac, a, d, rv, rdv, gd, dv, ev, lt, gb);
        chk("recovery done", 32'(dv), 32'(3'b100));
        chk("recovery rdata", 32'(rdv), 32'(16'hC3C3));
        req = '0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
